pipelined_alu_unit: RTL and testbench
=====================================

# pipelined_alu_unit

Parametrised, handshaked successor to the team's 4-bit registered ALU. It performs add, subtract, accumulate, bitwise logic and a multi-cycle shift-add multiply on WIDTH-bit operands, and reports carry, zero, negative and overflow flags. Both sides use valid/ready handshakes, so it can sit between an operand source and a result consumer that may stall. Single-cycle ops sustain one result per clock; MUL stalls the input side for WIDTH cycles.

## Interface
- WIDTH, 8: operand and result width; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand/op beat valid.
- in_ready  out  1  block can accept a beat.
- op  in  3  000 CLR, 001 ADD, 010 SUB, 011 ACC, 100 AND, 101 OR, 110 XOR, 111 MUL.
- operand_x  in  WIDTH  first operand.
- operand_y  in  WIDTH  second operand.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result low word.
- result_hi  out  WIDTH  MUL product high word; 0 for all other ops.
- flag_carry, flag_zero, flag_neg, flag_ovf  out  1 each  status flags for the presented result.

## Operation
- Accept happens on a rising edge when in_valid && in_ready. op and both operands are captured at that edge.
- States:
  - IDLE: no result held.
  - BUSY: MUL iterating.
  - DONE: result held, out_valid = 1.
- in_ready = rst_n && (state == IDLE || (state == DONE && out_ready)).
- Transitions:
  - IDLE or DONE, on accept of a non-MUL op → DONE.
  - IDLE or DONE, on accept of MUL → BUSY.
  - BUSY → DONE after WIDTH iterations.
  - DONE, out_ready high and no accept → IDLE.
- Ops:
  - CLR: result = 0. Also clears acc.
  - ADD: x + y.
  - SUB: x + ~y + 1.
  - ACC: acc + x; operand_y is ignored.
  - AND, OR, XOR: bitwise on x and y.
  - MUL: unsigned shift-add, one partial product per cycle, giving a 2·WIDTH-bit product in {result_hi, result}.
- acc is an internal WIDTH-bit register. It is loaded with result (low word) every time a result enters DONE, for every op including MUL.
- All add/sub arithmetic wraps modulo 2^WIDTH.
- Flags:
  - flag_carry: carry-out for ADD/ACC. For SUB it is the no-borrow bit (1 when x >= y unsigned). 0 for logic ops, CLR and MUL.
  - flag_ovf: two's-complement signed overflow for ADD/ACC/SUB. 0 otherwise.
  - flag_zero: set when the whole output is zero, i.e. {result_hi, result} == 0.
  - flag_neg: MSB of result_hi for MUL, MSB of result otherwise.
- Backpressure: while out_valid && !out_ready, result, result_hi and all flags are held stable, and no new beat is accepted.
- Inputs are ignored while in BUSY.

## Timing
- Reset (rst_n low at a rising edge):
  - state → IDLE; acc → 0.
  - out_valid, result, result_hi and all flags → 0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Reset during BUSY or DONE: the operation is abandoned and no out_valid is produced for it.
- Non-MUL latency is 1. A beat accepted at edge N has out_valid = 1 after edge N.
- MUL latency is WIDTH + 1. A beat accepted at edge N drives out_valid = 1 after edge N + WIDTH. in_ready is 0 during all BUSY cycles.
- Simultaneous consume and accept in DONE (out_ready && in_valid): the old result retires and the new beat is captured on the same edge, with no bubble for non-MUL ops.
- An ACC accepted on the same edge that the previous result retires uses that previous result as acc.
- Outputs are registered; the only combinational output path is in_ready from state, rst_n and out_ready.

## Test plan
All scenarios use WIDTH = 8.
- ADD 0xF0 + 0x20 → result 0x10, carry 1, ovf 0, zero 0; out_valid one cycle after accept.
- SUB 0x05 − 0x07 → 0xFE, carry 0, neg 1. Then SUB 0x80 − 0x01 → 0x7F, ovf 1, carry 1.
- MUL 0xFF × 0xFF → result_hi 0xFE, result 0x01; out_valid exactly 9 cycles after accept; in_ready 0 for 8 cycles. Also MUL 0x00 × 0x37 → zero 1.
- CLR, ACC x = 5, ACC x = 7, with out_ready held 1 and in_valid back-to-back → results 0, 5, 0x0C on consecutive cycles. Then ACC x = 0xF8 → 0x04, carry 1.
- XOR 0xAA ^ 0x55 with out_ready low for 3 cycles → result 0xFF held stable with neg 1 and in_ready 0; retires on the cycle out_ready rises.
- Assert rst_n low for one edge 3 cycles into a MUL → all outputs 0 and no out_valid. Then ACC x = 1 → result 0x01, proving acc was cleared.

Source files
------------

// File: rtl/pipelined_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_alu_unit
// Purpose  : Handshaked WIDTH-bit ALU with add/sub/accumulate/logic ops and a
//            multi-cycle shift-add multiply, plus carry/zero/neg/ovf flags.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_x,
    input  logic [WIDTH-1:0] operand_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_carry,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ACC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_q,     carry_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic             ovf_q,       ovf_d;
    logic [WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0] mul_hi_q,    mul_hi_d;
    logic [WIDTH-1:0] mul_lo_q,    mul_lo_d;
    logic [CW-1:0]    cnt_q,       cnt_d;

    logic             w_accept;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH:0]   w_add_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi_nx;
    logic [WIDTH-1:0] w_mul_lo_nx;

    assign in_ready = rst_n && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    // SUB is folded into the adder as x + ~y + 1 so carry is the no-borrow bit.
    always_comb begin
        w_add_a   = operand_x;
        w_add_b   = operand_y;
        w_add_cin = 1'b0;
        case (op)
            OP_SUB: begin
                w_add_b   = ~operand_y;
                w_add_cin = 1'b1;
            end
            OP_ACC: begin
                w_add_a = acc_q;
                w_add_b = operand_x;
            end
            default: ;
        endcase
    end

    assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                       (w_add_sum[WIDTH-1] != w_add_a[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ACC: begin
                w_alu_res = w_add_sum[WIDTH-1:0];
                w_alu_c   = w_add_sum[WIDTH];
                w_alu_v   = w_add_ovf;
            end
            OP_AND:  w_alu_res = operand_x & operand_y;
            OP_OR:   w_alu_res = operand_x | operand_y;
            OP_XOR:  w_alu_res = operand_x ^ operand_y;
            default: ;
        endcase
    end

    // One partial product per cycle; the multiplier shifts out of mul_lo while
    // product low bits shift in from the top.
    assign w_mul_sum   = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_nx = w_mul_sum[WIDTH:1];
    assign w_mul_lo_nx = {w_mul_sum[0], mul_lo_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        mcand_d     = mcand_q;
        mul_hi_d    = mul_hi_q;
        mul_lo_d    = mul_lo_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (op == OP_MUL) begin
                        state_d     = ST_BUSY;
                        out_valid_d = 1'b0;
                        mcand_d     = operand_x;
                        mul_hi_d    = '0;
                        mul_lo_d    = operand_y;
                        cnt_d       = '0;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = w_alu_res;
                        result_hi_d = '0;
                        acc_d       = w_alu_res;
                        carry_d     = w_alu_c;
                        ovf_d       = w_alu_v;
                        zero_d      = (w_alu_res == '0);
                        neg_d       = w_alu_res[WIDTH-1];
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                mul_hi_d = w_mul_hi_nx;
                mul_lo_d = w_mul_lo_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = w_mul_lo_nx;
                    result_hi_d = w_mul_hi_nx;
                    acc_d       = w_mul_lo_nx;
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = ({w_mul_hi_nx, w_mul_lo_nx} == '0);
                    neg_d       = w_mul_hi_nx[WIDTH-1];
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= '0;
            mul_hi_q    <= '0;
            mul_lo_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            mcand_q     <= mcand_d;
            mul_hi_q    <= mul_hi_d;
            mul_lo_q    <= mul_lo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
    assign flag_neg   = neg_q;
    assign flag_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_alu_unit
// Purpose  : Directed-vector bench for pipelined_alu_unit at WIDTH = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu_unit;

    localparam int W = 8;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ACC = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] operand_x;
    logic [W-1:0] operand_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_carry;
    logic         flag_zero;
    logic         flag_neg;
    logic         flag_ovf;

    int total = 0;
    int bad   = 0;

    pipelined_alu_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_x  (operand_x),
        .operand_y  (operand_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_ovf   (flag_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid  = 1'b1;
        op        = o;
        operand_x = x;
        operand_y = y;
    endtask

    // {out_valid, carry, zero, neg, ovf}
    function automatic logic [31:0] flags();
        return {27'd0, out_valid, flag_carry, flag_zero, flag_neg, flag_ovf};
    endfunction

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = OP_CLR;
        operand_x = '0;
        operand_y = '0;
        out_ready = 1'b1;

        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_flags",    flags(), 32'd0);
        check("rst_result",   {result_hi, result}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 0xF0 + 0x20
        beat(OP_ADD, 8'hF0, 8'h20);
        tick();
        in_valid = 1'b0;
        check("add_result", {24'd0, result}, 32'h10);
        check("add_flags",  flags(), 32'b11000);

        // SUB pair, back-to-back
        beat(OP_SUB, 8'h05, 8'h07);
        tick();
        check("sub1_result", {24'd0, result}, 32'hFE);
        check("sub1_flags",  flags(), 32'b10010);
        beat(OP_SUB, 8'h80, 8'h01);
        tick();
        in_valid = 1'b0;
        check("sub2_result", {24'd0, result}, 32'h7F);
        check("sub2_flags",  flags(), 32'b11001);
        tick();
        check("sub2_retired", {31'd0, out_valid}, 32'd0);

        // MUL 0xFF * 0xFF: 8 busy cycles with in_ready low
        beat(OP_MUL, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < W; i++) begin
            if (!in_ready && !out_valid) seen++;
            tick();
        end
        check("mul1_busy_cycles", seen, 32'd8);
        check("mul1_product", {16'd0, result_hi, result}, 32'hFE01);
        check("mul1_flags",   flags(), 32'b10010);

        // MUL 0x00 * 0x37 accepted while retiring the previous product
        beat(OP_MUL, 8'h00, 8'h37);
        tick();
        in_valid = 1'b0;
        check("mul2_started", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < W; i++) tick();
        check("mul2_product", {16'd0, result_hi, result}, 32'h0);
        check("mul2_flags",   flags(), 32'b10100);
        tick();

        // CLR, ACC 5, ACC 7, ACC 0xF8 back-to-back
        beat(OP_CLR, 8'h3C, 8'h3C);
        tick();
        check("clr_result", {24'd0, result}, 32'h00);
        check("clr_flags",  flags(), 32'b10100);
        beat(OP_ACC, 8'h05, 8'hAA);
        tick();
        check("acc5_result", {23'd0, out_valid, result}, 32'h105);
        beat(OP_ACC, 8'h07, 8'h55);
        tick();
        check("acc7_result", {23'd0, out_valid, result}, 32'h10C);
        beat(OP_ACC, 8'hF8, 8'h00);
        tick();
        in_valid = 1'b0;
        check("accf8_result", {24'd0, result}, 32'h04);
        check("accf8_flags",  flags(), 32'b11000);
        tick();

        // XOR held under backpressure for 3 cycles
        out_ready = 1'b0;
        beat(OP_XOR, 8'hAA, 8'h55);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("xor_hold_result", {24'd0, result}, 32'hFF);
            check("xor_hold_flags",  flags(), 32'b10010);
            check("xor_hold_ready",  {31'd0, in_ready}, 32'd0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        check("xor_ready_on_release", {31'd0, in_ready}, 32'd1);
        tick();
        check("xor_retired", {31'd0, out_valid}, 32'd0);

        // Reset 3 cycles into a MUL
        beat(OP_MUL, 8'h12, 8'h34);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mulrst_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        check("mulrst_flags",  flags(), 32'd0);
        check("mulrst_result", {16'd0, result_hi, result}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("mulrst_no_valid", seen, 32'd0);
        beat(OP_ACC, 8'h01, 8'hEE);
        tick();
        in_valid = 1'b0;
        check("acc_after_rst", {23'd0, out_valid, result}, 32'h101);
        check("acc_after_rst_flags", flags(), 32'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
